// File: rtl/uart_tx_core.sv
// UART transmitter core: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding buffer for back-to-back frames.
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_nxt;
  logic [PRESC_W-1:0]      cnt_q;
  logic [BIT_W-1:0]        bit_q, bit_nxt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q, par_typ_q;
  logic [PRESC_W-1:0]      presc_q;
  logic                    tick, accept, restart, load;
  logic [DATA_WIDTH-1:0]   src_data;
  logic                    src_par_en, src_par_typ;
  logic [PRESC_W-1:0]      src_presc, in_presc;
  logic                    tx_d, busy_d;

  assign tick     = (cnt_q == '0);
  assign accept   = (state_q == IDLE) && DATA_VALID;
  assign load     = accept || restart;
  assign in_presc = (Prescale == '0) ? PRESC_W'(1) : Prescale;

`ifdef UART_TX_HOLD_BUF_EN
  logic                  buf_valid_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  logic                  buf_par_en_q, buf_par_typ_q;
  logic [PRESC_W-1:0]    buf_presc_q;

  // Chain the next frame straight out of STOP, preferring a buffered request.
  assign restart = (state_q == STOP) && tick && (buf_valid_q || DATA_VALID);

  always_comb begin
    src_data    = P_DATA;
    src_par_en  = PAR_EN;
    src_par_typ = PAR_TYP;
    src_presc   = in_presc;
    if (buf_valid_q) begin
      src_data    = buf_data_q;
      src_par_en  = buf_par_en_q;
      src_par_typ = buf_par_typ_q;
      src_presc   = buf_presc_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_valid_q   <= 1'b0;
      buf_data_q    <= '0;
      buf_par_en_q  <= 1'b0;
      buf_par_typ_q <= 1'b0;
      buf_presc_q   <= '0;
    end else if (restart && buf_valid_q) begin
      buf_valid_q <= 1'b0;
    end else if (DATA_VALID && (state_q != IDLE) && !buf_valid_q && !restart) begin
      buf_valid_q   <= 1'b1;
      buf_data_q    <= P_DATA;
      buf_par_en_q  <= PAR_EN;
      buf_par_typ_q <= PAR_TYP;
      buf_presc_q   <= in_presc;
    end
  end
`else
  assign restart     = 1'b0;
  assign src_data    = P_DATA;
  assign src_par_en  = PAR_EN;
  assign src_par_typ = PAR_TYP;
  assign src_presc   = in_presc;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && (bit_q == LAST_BIT)) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick) state_nxt = restart ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_nxt = bit_q;
    if (load)
      bit_nxt = '0;
    else if ((state_q == DATA) && tick)
      bit_nxt = (bit_q == LAST_BIT) ? '0 : bit_q + BIT_W'(1);
  end

  // Line level follows the state being entered so TX_OUT registers in step with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_nxt];
      PARITY:  tx_d = (^data_q) ^ par_typ_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
      busy   <= 1'b0;
    end else begin
      TX_OUT <= tx_d;
      busy   <= busy_d;
    end
  end

  // Frame latches and bit timing; the down-counter reloads at every bit boundary.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      bit_q <= bit_nxt;
      if (load) begin
        data_q    <= src_data;
        par_en_q  <= src_par_en;
        par_typ_q <= src_par_typ;
        presc_q   <= src_presc;
        cnt_q     <= src_presc - PRESC_W'(1);
      end else if (state_q != IDLE) begin
        cnt_q <= tick ? presc_q - PRESC_W'(1) : cnt_q - PRESC_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter PRESC_W, default 6, meaning width of the Prescale port.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload.
REQ-006 SHALL have port DATA_VALID  input  1  request to send P_DATA.
REQ-007 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-009 SHALL have port Prescale  input  PRESC_W  CLK cycles per bit; 0 treated as 1.
REQ-010 SHALL have port TX_OUT  output  1  serial line, registered, idle high.
REQ-011 SHALL have port busy  output  1  registered; high while a frame is in flight.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL accept a request when DATA_VALID=1 at a rising edge in IDLE: latch P_DATA, PAR_EN, PAR_TYP, Prescale, go to START.
REQ-014 SHALL ignore DATA_VALID while busy=1 (no queuing unless REQ-027 applies).
REQ-015 SHALL drive TX_OUT=0 and busy=1 from the cycle after acceptance (latency 1 CLK).
REQ-016 SHALL hold each bit for exactly the latched Prescale cycles, timed by a down-counter reloaded at each bit boundary.
REQ-017 SHALL send DATA_WIDTH data bits LSB first in DATA, counted by a bit counter 0..DATA_WIDTH-1.
REQ-018 SHALL go DATA->PARITY when latched PAR_EN=1, else DATA->STOP, at the end of the last data bit.
REQ-019 SHALL make the parity bit the XOR of latched data for even, its inverse for odd.
REQ-020 SHALL drive TX_OUT=1 for one bit time in STOP, then enter IDLE with busy=0 on the following cycle.
REQ-021 SHALL frame length = (1+DATA_WIDTH+PAR_EN+1) x Prescale cycles, no gaps.
REQ-022 SHALL be unaffected by input changes mid-frame; only latched copies are used.
REQ-023 SHALL keep TX_OUT=1 in IDLE; an illegal state SHALL recover to IDLE with TX_OUT=1.

Reset
REQ-024 SHALL on RST=0 asynchronously set state IDLE, TX_OUT=1, busy=0, all counters and latches 0.
REQ-025 SHALL abort a frame on mid-frame reset with no partial resume; first acceptance possible on the first edge after RST deasserts.

Configuration
REQ-026 SHALL be controlled by macro UART_TX_HOLD_BUF_EN.
REQ-027 SHALL, with the macro defined, provide a one-entry holding buffer accepting DATA_VALID while busy=1 and buffer empty; the buffered frame starts in START on the cycle after STOP ends, with no idle bit and busy remaining 1; a request while the buffer is full is dropped.
REQ-028 SHALL, without the macro, have no buffer and behave exactly per REQ-014.

Verification
REQ-029 SHALL cover: P_DATA=0xA5, PAR_EN=0, Prescale=4 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles, busy high 40 cycles.
REQ-030 SHALL cover: P_DATA=0x03, PAR_EN=1, PAR_TYP=0, Prescale=1 -> parity bit 0; PAR_TYP=1 -> parity bit 1; 11-cycle frame.
REQ-031 SHALL cover: second DATA_VALID with 0x5A at mid-frame of 0xFF, macro off -> 0x5A never sent, TX_OUT stays 1 after first frame.
REQ-032 SHALL cover: same stimulus, macro on -> 0x5A frame start bit immediately follows 0xFF stop bit, busy continuous.
REQ-033 SHALL cover: RST=0 during bit 3 of 0x55 -> TX_OUT=1, busy=0 same cycle; new 0x81 after release sent intact.
REQ-034 SHALL cover: Prescale=0 -> each bit lasts 1 cycle; Prescale changed mid-frame 4->8 -> current frame keeps 4.
